// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit_if
// Purpose  : Execute/fetch-side signal bundle for the branch resolve unit.
// Revision : 1.0
// ============================================================================
interface branch_resolve_unit_if #(
    parameter int OPCODEWIDTH = 4,
    parameter int PCWIDTH     = 32,
    parameter int CNTWIDTH    = 16
);
    logic                   enE;
    logic                   stallE;
    logic [OPCODEWIDTH-1:0] opcodeE;
    logic [PCWIDTH-1:0]     pcE;
    logic                   predTakenE;
    logic                   flagsWriteE;
    logic [3:0]             aluFlagsE;
    logic [PCWIDTH-1:0]     pcF;
    logic                   predTakenF;
    logic                   takeBranchE;
    logic                   takeBranchM;
    logic                   mispredictM;
    logic [3:0]             flagsOut;
    logic [CNTWIDTH-1:0]    branchCount;
    logic [CNTWIDTH-1:0]    mispredictCount;

    modport master (
        output enE, stallE, opcodeE, pcE, predTakenE, flagsWriteE, aluFlagsE, pcF,
        input  predTakenF, takeBranchE, takeBranchM, mispredictM, flagsOut,
               branchCount, mispredictCount
    );

    modport slave (
        input  enE, stallE, opcodeE, pcE, predTakenE, flagsWriteE, aluFlagsE, pcF,
        output predTakenF, takeBranchE, takeBranchM, mispredictM, flagsOut,
               branchCount, mispredictCount
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : NZVC flag register, branch condition evaluation, 2-bit BHT and
//            registered taken/mispredict results with saturating statistics.
// Revision : 1.0
// ============================================================================
module branch_resolve_unit #(
    parameter int                     OPCODEWIDTH = 4,
    parameter int                     PCWIDTH     = 32,
    parameter int                     BHT_ENTRIES = 16,
    parameter int                     CNTWIDTH    = 16,
    parameter logic [OPCODEWIDTH-1:0] OP_BEQ      = 4'b1011,
    parameter logic [OPCODEWIDTH-1:0] OP_BNE      = 4'b1100,
    parameter logic [OPCODEWIDTH-1:0] OP_BLT      = 4'b1101,
    parameter logic [OPCODEWIDTH-1:0] OP_BGE      = 4'b1110,
    parameter logic [OPCODEWIDTH-1:0] OP_B        = 4'b1111
) (
    input  wire logic            clk,
    input  wire logic            reset,
    branch_resolve_unit_if.slave bru
);
    localparam int IDXW = $clog2(BHT_ENTRIES);

    logic [3:0]          r_flags;
    logic [1:0]          r_bht [BHT_ENTRIES];
    logic                r_take_m;
    logic                r_mispredict_m;
    logic [CNTWIDTH-1:0] r_branch_count;
    logic [CNTWIDTH-1:0] r_mispredict_count;

    logic            w_is_branch;
    logic            w_cond;
    logic            w_take;
    logic            w_fire;
    logic            w_mispredict;
    logic [IDXW-1:0] w_idx_e;
    logic [IDXW-1:0] w_idx_f;
    logic            w_unused_bits;

    assign w_is_branch = bru.enE & ((bru.opcodeE == OP_BEQ) | (bru.opcodeE == OP_BNE) |
                                    (bru.opcodeE == OP_BLT) | (bru.opcodeE == OP_BGE) |
                                    (bru.opcodeE == OP_B));

    // Conditions read the architectural register, never the ALU's in-flight flags.
    always_comb begin
        w_cond = 1'b0;
        if (bru.opcodeE == OP_BEQ)      w_cond = r_flags[2];
        else if (bru.opcodeE == OP_BNE) w_cond = ~r_flags[2];
        else if (bru.opcodeE == OP_BLT) w_cond = r_flags[3] ^ r_flags[1];
        else if (bru.opcodeE == OP_BGE) w_cond = ~(r_flags[3] ^ r_flags[1]);
        else if (bru.opcodeE == OP_B)   w_cond = 1'b1;
    end

    assign w_take       = w_is_branch & w_cond;
    assign w_fire       = w_is_branch & ~bru.stallE;
    assign w_mispredict = w_fire & (w_take != bru.predTakenE);
    assign w_idx_e      = bru.pcE[IDXW+1:2];
    assign w_idx_f      = bru.pcF[IDXW+1:2];

    assign w_unused_bits = ^{bru.pcE[PCWIDTH-1:IDXW+2], bru.pcE[1:0],
                             bru.pcF[PCWIDTH-1:IDXW+2], bru.pcF[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (bru.enE && bru.flagsWriteE && !bru.stallE) begin
            r_flags <= bru.aluFlagsE;
        end
    end

    // Predictor table resets to weakly-not-taken; saturating 2-bit update on fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_fire) begin
            if (w_take && (r_bht[w_idx_e] != 2'b11)) begin
                r_bht[w_idx_e] <= r_bht[w_idx_e] + 2'b01;
            end else if (!w_take && (r_bht[w_idx_e] != 2'b00)) begin
                r_bht[w_idx_e] <= r_bht[w_idx_e] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_take_m       <= 1'b0;
            r_mispredict_m <= 1'b0;
        end else begin
            r_take_m       <= w_fire & w_take;
            r_mispredict_m <= w_mispredict;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_fire) begin
            if (r_branch_count != '1) begin
                r_branch_count <= r_branch_count + 1'b1;
            end
            if (w_mispredict && (r_mispredict_count != '1)) begin
                r_mispredict_count <= r_mispredict_count + 1'b1;
            end
        end
    end

    assign bru.predTakenF      = r_bht[w_idx_f][1];
    assign bru.takeBranchE     = w_take;
    assign bru.takeBranchM     = r_take_m;
    assign bru.mispredictM     = r_mispredict_m;
    assign bru.flagsOut        = r_flags;
    assign bru.branchCount     = r_branch_count;
    assign bru.mispredictCount = r_mispredict_count;
endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Directed vector table plus hand sequences for branch_resolve_unit.
// Revision : 1.0
// ============================================================================
module tb_branch_resolve_unit;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.OPCODEWIDTH(4), .PCWIDTH(32), .CNTWIDTH(16)) bif ();
    branch_resolve_unit_if #(.OPCODEWIDTH(4), .PCWIDTH(32), .CNTWIDTH(4))  bif4 ();

    branch_resolve_unit #(.OPCODEWIDTH(4), .PCWIDTH(32), .BHT_ENTRIES(16), .CNTWIDTH(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bru  (bif.slave)
    );

    branch_resolve_unit #(.OPCODEWIDTH(4), .PCWIDTH(32), .BHT_ENTRIES(16), .CNTWIDTH(4)) dut4 (
        .clk  (clk),
        .reset(reset),
        .bru  (bif4.slave)
    );

    typedef struct {
        logic        en;
        logic        st;
        logic [3:0]  op;
        logic [31:0] pc;
        logic        pt;
        logic        fw;
        logic [3:0]  alu;
        logic [31:0] pcf;
        logic        exp_te;
        logic        exp_pf;
        logic        exp_tm;
        logic        exp_mm;
        logic [3:0]  exp_fl;
        int          exp_bc;
        int          exp_mc;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic en, input logic st, input logic [3:0] op, input logic [31:0] pc,
                       input logic pt, input logic fw, input logic [3:0] alu);
        @(negedge clk);
        bif.enE         = en;
        bif.stallE      = st;
        bif.opcodeE     = op;
        bif.pcE         = pc;
        bif.predTakenE  = pt;
        bif.flagsWriteE = fw;
        bif.aluFlagsE   = alu;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic en, input logic st, input logic [3:0] op, input logic [31:0] pc,
                       input logic pt, input logic fw, input logic [3:0] alu);
        drv(en, st, op, pc, pt, fw, alu);
        step();
    endtask

    task automatic run_vec(input vec_t v, input int k);
        drv(v.en, v.st, v.op, v.pc, v.pt, v.fw, v.alu);
        bif.pcF = v.pcf;
        #1;
        chk($sformatf("v%0d takeBranchE", k), 32'(bif.takeBranchE), 32'(v.exp_te));
        chk($sformatf("v%0d predTakenF", k), 32'(bif.predTakenF), 32'(v.exp_pf));
        step();
        chk($sformatf("v%0d takeBranchM", k), 32'(bif.takeBranchM), 32'(v.exp_tm));
        chk($sformatf("v%0d mispredictM", k), 32'(bif.mispredictM), 32'(v.exp_mm));
        chk($sformatf("v%0d flagsOut", k), 32'(bif.flagsOut), 32'(v.exp_fl));
        chk($sformatf("v%0d branchCount", k), 32'(bif.branchCount), 32'(v.exp_bc));
        chk($sformatf("v%0d mispredictCount", k), 32'(bif.mispredictCount), 32'(v.exp_mc));
    endtask

    initial begin
        //            en    st    op       pc      pt    fw    alu      pcF     tE    pF    tM    mM    flags  bc mc
        vecs[0]  = '{1'b1, 1'b0, 4'b0001, 32'h00, 1'b0, 1'b1, 4'b0100, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 0, 0};
        vecs[1]  = '{1'b1, 1'b0, 4'b1011, 32'h40, 1'b0, 1'b0, 4'b0000, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 1, 1};
        vecs[2]  = '{1'b0, 1'b0, 4'b0000, 32'h00, 1'b0, 1'b0, 4'b0000, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 1, 1};
        vecs[3]  = '{1'b1, 1'b0, 4'b0010, 32'h00, 1'b0, 1'b1, 4'b0000, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1, 1};
        vecs[4]  = '{1'b1, 1'b0, 4'b0010, 32'h00, 1'b0, 1'b1, 4'b0100, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1, 1};
        vecs[5]  = '{1'b1, 1'b0, 4'b1100, 32'h44, 1'b1, 1'b0, 4'b0000, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 2, 2};
        vecs[6]  = '{1'b1, 1'b0, 4'b0011, 32'h00, 1'b0, 1'b1, 4'b1000, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 2, 2};
        vecs[7]  = '{1'b1, 1'b0, 4'b1101, 32'h48, 1'b0, 1'b0, 4'b0110, 32'h48, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 3, 3};
        vecs[8]  = '{1'b1, 1'b0, 4'b0011, 32'h00, 1'b0, 1'b1, 4'b1010, 32'h48, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 3, 3};
        vecs[9]  = '{1'b1, 1'b0, 4'b1110, 32'h48, 1'b1, 1'b0, 4'b0001, 32'h48, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1010, 4, 3};
        vecs[10] = '{1'b1, 1'b0, 4'b1011, 32'h4C, 1'b0, 1'b0, 4'b0100, 32'h4C, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 5, 3};
        vecs[11] = '{1'b1, 1'b0, 4'b1111, 32'h4C, 1'b0, 1'b0, 4'b0000, 32'h4C, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1010, 6, 4};
        vecs[12] = '{1'b0, 1'b0, 4'b1011, 32'h4C, 1'b0, 1'b1, 4'b1111, 32'h4C, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 6, 4};
        vecs[13] = '{1'b1, 1'b0, 4'b1010, 32'h4C, 1'b1, 1'b0, 4'b0000, 32'h4C, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 6, 4};

        bif.enE = 1'b0; bif.stallE = 1'b0; bif.opcodeE = 4'b0000; bif.pcE = 32'h0;
        bif.predTakenE = 1'b0; bif.flagsWriteE = 1'b0; bif.aluFlagsE = 4'b0000; bif.pcF = 32'h0;
        bif4.enE = 1'b0; bif4.stallE = 1'b0; bif4.opcodeE = 4'b0000; bif4.pcE = 32'h0;
        bif4.predTakenE = 1'b0; bif4.flagsWriteE = 1'b0; bif4.aluFlagsE = 4'b0000; bif4.pcF = 32'h0;

        // Reset state
        #2 reset = 1'b1;
        #1;
        chk("rst takeBranchM", 32'(bif.takeBranchM), 32'h0);
        chk("rst mispredictM", 32'(bif.mispredictM), 32'h0);
        chk("rst flagsOut", 32'(bif.flagsOut), 32'h0);
        chk("rst branchCount", 32'(bif.branchCount), 32'h0);
        chk("rst mispredictCount", 32'(bif.mispredictCount), 32'h0);
        chk("rst takeBranchE", 32'(bif.takeBranchE), 32'h0);
        chk("rst dut4 branchCount", 32'(bif4.branchCount), 32'h0);
        for (int i = 0; i < 16; i++) begin
            bif.pcF = 32'(i * 4);
            #1;
            chk($sformatf("rst predTakenF idx%0d", i), 32'(bif.predTakenF), 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 14; k++) begin
            run_vec(vecs[k], k);
        end

        // Saturation and aliasing: 0x80 and 0xC0 share index 0 (entry currently 10)
        cyc(1'b1, 1'b0, 4'b0010, 32'h00, 1'b0, 1'b1, 4'b0100);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 4'b1011, 32'h80, 1'b1, 1'b0, 4'b0000);
        bif.pcF = 32'hC0;
        #1;
        chk("sat alias taken predTakenF", 32'(bif.predTakenF), 32'h1);
        cyc(1'b1, 1'b0, 4'b0010, 32'h00, 1'b0, 1'b1, 4'b0000);
        bif.pcF = 32'h80;
        cyc(1'b1, 1'b0, 4'b1011, 32'hC0, 1'b0, 1'b0, 4'b0000);
        chk("sat top 11->10 predTakenF", 32'(bif.predTakenF), 32'h1);
        cyc(1'b1, 1'b0, 4'b1011, 32'hC0, 1'b0, 1'b0, 4'b0000);
        chk("sat 10->01 predTakenF", 32'(bif.predTakenF), 32'h0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 4'b1011, 32'h80, 1'b0, 1'b0, 4'b0000);
        cyc(1'b1, 1'b0, 4'b0010, 32'h00, 1'b0, 1'b1, 4'b0100);
        cyc(1'b1, 1'b0, 4'b1011, 32'h80, 1'b1, 1'b0, 4'b0000);
        chk("sat bottom 00->01 predTakenF", 32'(bif.predTakenF), 32'h0);
        cyc(1'b1, 1'b0, 4'b1011, 32'h80, 1'b1, 1'b0, 4'b0000);
        chk("sat 01->10 predTakenF", 32'(bif.predTakenF), 32'h1);
        chk("sat branchCount", 32'(bif.branchCount), 32'd18);
        chk("sat mispredictCount", 32'(bif.mispredictCount), 32'd4);

        // Stall: three stalled BEQs at 0x50 (Z=1) then a stalled flag write
        bif.pcF = 32'h50;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b1, 4'b1011, 32'h50, 1'b0, 1'b0, 4'b0000);
            #1;
            chk($sformatf("stall%0d takeBranchE", i), 32'(bif.takeBranchE), 32'h1);
            step();
            chk($sformatf("stall%0d takeBranchM", i), 32'(bif.takeBranchM), 32'h0);
            chk($sformatf("stall%0d mispredictM", i), 32'(bif.mispredictM), 32'h0);
            chk($sformatf("stall%0d branchCount", i), 32'(bif.branchCount), 32'd18);
            chk($sformatf("stall%0d mispredictCount", i), 32'(bif.mispredictCount), 32'd4);
            chk($sformatf("stall%0d predTakenF", i), 32'(bif.predTakenF), 32'h0);
        end
        cyc(1'b1, 1'b1, 4'b0010, 32'h00, 1'b0, 1'b1, 4'b0000);
        chk("stall flagsOut held", 32'(bif.flagsOut), 32'h4);
        cyc(1'b1, 1'b0, 4'b1011, 32'h50, 1'b0, 1'b0, 4'b0000);
        chk("release takeBranchM", 32'(bif.takeBranchM), 32'h1);
        chk("release mispredictM", 32'(bif.mispredictM), 32'h1);
        chk("release branchCount", 32'(bif.branchCount), 32'd19);
        chk("release mispredictCount", 32'(bif.mispredictCount), 32'd5);
        chk("release predTakenF", 32'(bif.predTakenF), 32'h1);
        cyc(1'b0, 1'b0, 4'b0000, 32'h00, 1'b0, 1'b0, 4'b0000);
        chk("bubble takeBranchM", 32'(bif.takeBranchM), 32'h0);
        chk("bubble mispredictM", 32'(bif.mispredictM), 32'h0);
        chk("bubble branchCount", 32'(bif.branchCount), 32'd19);

        // Asynchronous reset mid-stall, sampled before the next rising edge
        drv(1'b1, 1'b1, 4'b1011, 32'h50, 1'b0, 1'b0, 4'b0000);
        #2 reset = 1'b1;
        #1;
        chk("async branchCount", 32'(bif.branchCount), 32'h0);
        chk("async mispredictCount", 32'(bif.mispredictCount), 32'h0);
        chk("async flagsOut", 32'(bif.flagsOut), 32'h0);
        chk("async predTakenF", 32'(bif.predTakenF), 32'h0);
        drv(1'b0, 1'b0, 4'b0000, 32'h00, 1'b0, 1'b0, 4'b0000);
        reset = 1'b0;
        step();
        chk("post-reset takeBranchM", 32'(bif.takeBranchM), 32'h0);

        // 4-bit counters: 20 mispredicting BEQs (Z=0, predicted taken)
        @(negedge clk);
        bif4.enE = 1'b1; bif4.opcodeE = 4'b1011; bif4.pcE = 32'h40; bif4.predTakenE = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 13) begin
                chk("cnt4 branchCount 14", 32'(bif4.branchCount), 32'd14);
                chk("cnt4 mispredictCount 14", 32'(bif4.mispredictCount), 32'd14);
            end
            if (i == 14) chk("cnt4 branchCount 15", 32'(bif4.branchCount), 32'd15);
        end
        chk("cnt4 branchCount sat", 32'(bif4.branchCount), 32'd15);
        chk("cnt4 mispredictCount sat", 32'(bif4.mispredictCount), 32'd15);
        chk("cnt4 mispredictM", 32'(bif4.mispredictM), 32'h1);
        @(negedge clk);
        bif4.enE = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
